// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: instruction classes, forwarding selects and
// the decode pipeline register layout.
package pipe_pkg;

  localparam logic [3:0] INS_NOP   = 4'h0;
  localparam logic [3:0] INS_IRMOV = 4'h1;
  localparam logic [3:0] INS_RRMOV = 4'h2;
  localparam logic [3:0] INS_OP    = 4'h3;
  localparam logic [3:0] INS_MRMOV = 4'h4;
  localparam logic [3:0] INS_JXX   = 4'h5;

  // Operand select seen by execute: register value, ALU result of the
  // instruction now in E (arriving from M), result of the one now in M
  // (arriving from W), or the immediate/zero constant.
  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_M   = 2'b01;
  localparam logic [1:0] SEL_W   = 2'b10;
  localparam logic [1:0] SEL_C   = 2'b11;

  typedef struct packed {
    logic [3:0] ins_code;
    logic [3:0] fun_code;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] val_c;
  } instr_t;

  typedef struct packed {
    instr_t     ins;
    logic [7:0] pc;
  } dreg_t;

  localparam instr_t NOP_INSTR = '0;

  // A used source takes the youngest in-flight producer; an unused one
  // keeps the class constant.
  function automatic logic [1:0] fwd_sel(input logic       used,
                                         input logic [1:0] fixed,
                                         input logic [3:0] src,
                                         input logic       we_e,
                                         input logic [3:0] dst_e,
                                         input logic       we_m,
                                         input logic [3:0] dst_m);
    logic [1:0] sel;
    sel = fixed;
    if (used) begin
      if (we_e && dst_e == src)      sel = SEL_M;
      else if (we_m && dst_m == src) sel = SEL_W;
      else                           sel = SEL_REG;
    end
    return sel;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Signal bundle around the decode stage: fetch word, E/M/W feedback and the
// decoded operands handed to execute.
interface decode_stage_if #(parameter int WIDTH = 8);
  logic [23:0]      ins_f;
  logic [7:0]       increPC_f;
  logic             jmpFlag_e;
  logic             writeReg_e;
  logic             writeAluMem_e;
  logic [3:0]       dst_e;
  logic             writeReg_m;
  logic [3:0]       dst_m;
  logic             writeReg_w;
  logic [3:0]       dst_w;
  logic [WIDTH-1:0] regData_w;

  logic             stall_f;
  logic             nop_E;
  logic [3:0]       insCode_d;
  logic [3:0]       funCode_d;
  logic [3:0]       dst_d;
  logic [WIDTH-1:0] regA_d;
  logic [WIDTH-1:0] regB_d;
  logic [7:0]       valC_d;
  logic [7:0]       increPC_d;
  logic [1:0]       selA_d;
  logic [1:0]       selB_d;
  logic             writeReg_d;
  logic             writeAluMem_d;

  modport master (
    input  ins_f, increPC_f, jmpFlag_e, writeReg_e, writeAluMem_e, dst_e,
           writeReg_m, dst_m, writeReg_w, dst_w, regData_w,
    output stall_f, nop_E, insCode_d, funCode_d, dst_d, regA_d, regB_d,
           valC_d, increPC_d, selA_d, selB_d, writeReg_d, writeAluMem_d
  );

  modport slave (
    output ins_f, increPC_f, jmpFlag_e, writeReg_e, writeAluMem_e, dst_e,
           writeReg_m, dst_m, writeReg_w, dst_w, regData_w,
    input  stall_f, nop_E, insCode_d, funCode_d, dst_d, regA_d, regB_d,
           valC_d, increPC_d, selA_d, selB_d, writeReg_d, writeAluMem_d
  );
endinterface

// File: rtl/decode_stage_reg_file.sv
// Register file: two combinational read ports with write-through bypass,
// one write port committed at posedge.
module reg_file #(
  parameter int NREG  = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  assign rdata_a = (we && waddr == raddr_a) ? wdata : regs_q[raddr_a];
  assign rdata_b = (we && waddr == raddr_b) ? wdata : regs_q[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: D pipeline register, instruction class decode, operand
// forwarding selects, load-use stall and jump flush.
module decode_stage
  import pipe_pkg::*;
#(
  parameter int NREG  = 16,
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.master bus
);

  dreg_t            dreg_q, dreg_d;
  logic             use_a, use_b;
  logic [1:0]       fix_a, fix_b;
  logic             wr, wam, load_use;
  logic [3:0]       dst, code;
  logic [WIDTH-1:0] rdata_a, rdata_b;

  reg_file #(.NREG(NREG), .WIDTH(WIDTH)) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (dreg_q.ins.ra),
    .raddr_b (dreg_q.ins.rb),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (bus.writeReg_w),
    .waddr   (bus.dst_w),
    .wdata   (bus.regData_w)
  );

  always_comb begin
    use_a = 1'b0;
    use_b = 1'b0;
    fix_a = SEL_REG;
    fix_b = SEL_REG;
    wr    = 1'b0;
    wam   = 1'b0;
    dst   = '0;
    code  = dreg_q.ins.ins_code;
    case (dreg_q.ins.ins_code)
      INS_NOP:   code = INS_NOP;
      INS_IRMOV: begin fix_a = SEL_C; fix_b = SEL_C; wr = 1'b1; dst = dreg_q.ins.rb; end
      INS_RRMOV: begin use_a = 1'b1; fix_b = SEL_C; wr = 1'b1; dst = dreg_q.ins.rb; end
      INS_OP:    begin use_a = 1'b1; use_b = 1'b1; wr = 1'b1; dst = dreg_q.ins.rb; end
      INS_MRMOV: begin use_a = 1'b1; fix_b = SEL_C; wr = 1'b1; wam = 1'b1; dst = dreg_q.ins.rb; end
      INS_JXX:   begin use_a = 1'b1; use_b = 1'b1; end
      default:   code = INS_NOP;
    endcase
  end

  // A load in E cannot forward in time; hold D one cycle unless a taken
  // jump is squashing it anyway.
  always_comb begin
    load_use = bus.writeReg_e && bus.writeAluMem_e &&
               ((use_a && bus.dst_e == dreg_q.ins.ra) ||
                (use_b && bus.dst_e == dreg_q.ins.rb));
    dreg_d = dreg_q;
    if (bus.jmpFlag_e) begin
      dreg_d.ins = NOP_INSTR;
      dreg_d.pc  = '0;
    end else if (!load_use) begin
      dreg_d.ins = bus.ins_f;
      dreg_d.pc  = bus.increPC_f;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dreg_q <= '0;
    else     dreg_q <= dreg_d;
  end

  assign bus.stall_f       = load_use && !bus.jmpFlag_e;
  assign bus.nop_E         = load_use || bus.jmpFlag_e;
  assign bus.insCode_d     = code;
  assign bus.funCode_d     = dreg_q.ins.fun_code;
  assign bus.dst_d         = dst;
  assign bus.regA_d        = rdata_a;
  assign bus.regB_d        = rdata_b;
  assign bus.valC_d        = dreg_q.ins.val_c;
  assign bus.increPC_d     = dreg_q.pc;
  assign bus.writeReg_d    = wr;
  assign bus.writeAluMem_d = wam;
  assign bus.selA_d = fwd_sel(use_a, fix_a, dreg_q.ins.ra, bus.writeReg_e, bus.dst_e,
                              bus.writeReg_m, bus.dst_m);
  assign bus.selB_d = fwd_sel(use_b, fix_b, dreg_q.ins.rb, bus.writeReg_e, bus.dst_e,
                              bus.writeReg_m, bus.dst_m);

endmodule
